// File: rtl/neighbor_table_reader.sv
// Scans the neighbor region of node memory and returns the neighbor with the highest Q-value.
// Build option: define SIGNED_Q_EN to compare Q-values as two's-complement instead of unsigned.
module neighbor_table_reader #(
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 16,
    parameter int                MAX_NEIGH = 8,
    parameter logic [ADDR_W-1:0] Q_BASE    = 11'd64,
    parameter logic [ADDR_W-1:0] NODE_BASE = 11'd32
) (
    input  logic              clock,
    input  logic              nrst,
    input  logic              en,
    input  logic              start,
    input  logic [3:0]        neigh_count,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] besthop,
    output logic [DATA_W-1:0] bestq,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, QADDR, QDATA, NDATA, DONE} state_t;

    localparam logic [3:0] MAX_N = 4'(MAX_NEIGH);

    state_t            state, state_nxt;
    logic [3:0]        k, k_nxt;
    logic [3:0]        n, n_nxt;
    logic [3:0]        n_req;
    logic [3:0]        k_inc;
    logic [ADDR_W-1:0] address_nxt;
    logic [DATA_W-1:0] qcap, qcap_nxt;
    logic [DATA_W-1:0] besthop_nxt, bestq_nxt;
    logic              found, found_nxt;
    logic              busy_nxt, done_nxt;
    logic              q_better;

    assign n_req = (neigh_count > MAX_N) ? MAX_N : neigh_count;
    assign k_inc = k + 4'd1;

    // Strict compare: equal Q-values keep the earlier (lower index) winner.
`ifdef SIGNED_Q_EN
    assign q_better = $signed(qcap) > $signed(bestq);
`else
    assign q_better = qcap > bestq;
`endif

    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        n_nxt       = n;
        address_nxt = address;
        qcap_nxt    = qcap;
        besthop_nxt = besthop;
        bestq_nxt   = bestq;
        found_nxt   = found;
        case (state)
            IDLE: begin
                if (start) begin
                    n_nxt     = n_req;
                    found_nxt = 1'b0;
                    k_nxt     = 4'd0;
                    if (n_req == 4'd0) begin
                        besthop_nxt = '1;
                        bestq_nxt   = '0;
                        state_nxt   = DONE;
                    end else begin
                        address_nxt = Q_BASE;
                        state_nxt   = QADDR;
                    end
                end
            end
            QADDR: begin
                address_nxt = NODE_BASE + ADDR_W'(k);
                state_nxt   = QDATA;
            end
            QDATA: begin
                qcap_nxt  = data_in;
                state_nxt = NDATA;
            end
            NDATA: begin
                // First entry always wins so stale bestq from a previous scan never matters.
                if (!found || q_better) begin
                    besthop_nxt = data_in;
                    bestq_nxt   = qcap;
                    found_nxt   = 1'b1;
                end
                if (k == n - 4'd1) begin
                    state_nxt = DONE;
                end else begin
                    k_nxt       = k_inc;
                    address_nxt = Q_BASE + ADDR_W'(k_inc);
                    state_nxt   = QADDR;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == QADDR) || (state_nxt == QDATA) || (state_nxt == NDATA);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            k       <= '0;
            n       <= '0;
            address <= '0;
            qcap    <= '0;
            besthop <= '1;
            bestq   <= '0;
            found   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (en) begin
            state   <= state_nxt;
            k       <= k_nxt;
            n       <= n_nxt;
            address <= address_nxt;
            qcap    <= qcap_nxt;
            besthop <= besthop_nxt;
            bestq   <= bestq_nxt;
            found   <= found_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

endmodule
